// File: rtl/cordic_pkg.sv
// Shared constants, command-word layout and FSM state type for the CORDIC input stage.
package cordic_pkg;

  localparam int ANGLE_P90  = 90;
  localparam int ANGLE_N90  = -90;
  localparam int ANGLE_P180 = 180;
  localparam int ANGLE_P360 = 360;

  // Command word layout: degree / tan field starts at DEG_LSB, mode bit at ARCTAN_BIT.
  localparam int DEG_LSB    = 0;
  localparam int ARCTAN_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_PUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_in_fifo.sv
// Synchronous FIFO with occupancy count. Writes while full and reads while empty are ignored.
module cordic_in_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Memory is reset so the head reads as zero while the FIFO is empty after reset.
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer, storage and count update; push and pop together leave the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cordic_input_stage.sv
// Registered CORDIC input stage: accepts a command word, brings the angle into
// [-180,180], folds it into [-90,90] with a flip flag and queues the operands.
// Optional build macro CORDIC_IN_CLAMP_EN: clamp out-of-range angles to +/-180
// instead of modulo-360 reduction, and expose a sticky range_err output.
//
// state     | meaning
// ST_IDLE   | waiting for a command, in_ready high when the FIFO has room
// ST_REDUCE | stepping the angle by 360 degrees per cycle until in range
// ST_PUSH   | folding the angle and writing one FIFO entry
module cordic_input_stage
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH     = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int FLIP_FLAG_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                in_word,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ANGLE_WIDTH-1:0]     degree_out,
  output logic [DATA_WIDTH-1:0]      x_out,
  output logic [DATA_WIDTH-1:0]      y_out,
  output logic [FLIP_FLAG_WIDTH-1:0] flip_out,
  output logic                       arctan_en_out,
  output logic                       out_valid,
`ifdef CORDIC_IN_CLAMP_EN
  output logic                       range_err,
`endif
  input  logic                       out_ready
);

  // One extra bit of headroom so +/-360 steps and folds never overflow.
  typedef logic signed [ANGLE_WIDTH:0] wang_t;

  localparam wang_t P90  = wang_t'(ANGLE_P90);
  localparam wang_t N90  = wang_t'(ANGLE_N90);
  localparam wang_t P180 = wang_t'(ANGLE_P180);
  localparam wang_t N180 = wang_t'(-ANGLE_P180);
  localparam wang_t P360 = wang_t'(ANGLE_P360);
  localparam logic [DATA_WIDTH-1:0] X_UNITY = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRAC_WIDTH;
  localparam int EW = 1 + FLIP_FLAG_WIDTH + ANGLE_WIDTH + 2 * DATA_WIDTH;

  state_e                 state_q, state_d;
  wang_t                  angle_q, angle_d;
  logic [DATA_WIDTH-1:0]  tan_q, tan_d;
  logic                   arctan_q, arctan_d;

  wang_t                  in_angle, angle_step, fold_angle;
  logic                   in_angle_ok, step_ok, in_arctan, accept, push;
  logic                   fifo_full, fifo_empty;
  logic [FLIP_FLAG_WIDTH-1:0] fold_flip;
  logic [ANGLE_WIDTH-1:0] ent_deg;
  logic [FLIP_FLAG_WIDTH-1:0] ent_flip;
  logic [DATA_WIDTH-1:0]  ent_y;
  logic [EW-1:0]          ent_data, head_data;
  logic                   unused_in;

`ifdef CORDIC_IN_CLAMP_EN
  logic range_err_q, range_err_d;
  assign range_err = range_err_q;
`endif

  assign unused_in   = ^in_word[31:ARCTAN_BIT+1];
  assign in_arctan   = in_word[ARCTAN_BIT];
  assign in_angle    = wang_t'($signed(in_word[DEG_LSB +: ANGLE_WIDTH]));
  assign in_angle_ok = (in_angle <= P180) && (in_angle >= N180);
  assign angle_step  = (angle_q > P180) ? (angle_q - P360) : (angle_q + P360);
  assign step_ok     = (angle_step <= P180) && (angle_step >= N180);
  // rst_n is folded in so in_ready drops the moment reset asserts.
  assign in_ready    = rst_n && (state_q == ST_IDLE) && !fifo_full;
  assign accept      = in_valid && in_ready;
  assign out_valid   = !fifo_empty;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      angle_q  <= '0;
      tan_q    <= '0;
      arctan_q <= 1'b0;
`ifdef CORDIC_IN_CLAMP_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      tan_q    <= tan_d;
      arctan_q <= arctan_d;
`ifdef CORDIC_IN_CLAMP_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef CORDIC_IN_CLAMP_EN
          state_d = ST_PUSH;
`else
          if (!in_arctan && !in_angle_ok) state_d = ST_REDUCE;
          else                            state_d = ST_PUSH;
`endif
        end
      end
      ST_REDUCE: if (step_ok) state_d = ST_PUSH;
      ST_PUSH:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: command capture, reduction steps and the FIFO write strobe.
  always_comb begin
    angle_d  = angle_q;
    tan_d    = tan_q;
    arctan_d = arctan_q;
    push     = 1'b0;
`ifdef CORDIC_IN_CLAMP_EN
    range_err_d = range_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          angle_d  = in_angle;
          tan_d    = in_word[DEG_LSB +: DATA_WIDTH];
          arctan_d = in_arctan;
`ifdef CORDIC_IN_CLAMP_EN
          if (!in_arctan && !in_angle_ok) begin
            angle_d     = (in_angle > P180) ? P180 : N180;
            range_err_d = 1'b1;
          end
`endif
        end
      end
      ST_REDUCE: angle_d = angle_step;
      ST_PUSH:   push = 1'b1;
      default:   ;
    endcase
  end

  // Fold into [-90,90] and assemble the FIFO entry; arctan mode bypasses the fold.
  always_comb begin
    fold_angle = angle_q;
    fold_flip  = '0;
    if (angle_q > P90) begin
      fold_angle   = angle_q - P180;
      fold_flip[0] = 1'b1;
    end else if (angle_q < N90) begin
      fold_angle   = angle_q + P180;
      fold_flip[0] = 1'b1;
    end
    ent_deg  = arctan_q ? '0 : fold_angle[ANGLE_WIDTH-1:0];
    ent_flip = arctan_q ? '0 : fold_flip;
    ent_y    = arctan_q ? tan_q : '0;
    ent_data = {arctan_q, ent_flip, ent_deg, X_UNITY, ent_y};
  end

  cordic_in_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(ent_data),
    .pop  (out_valid && out_ready),
    .rdata(head_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign {arctan_en_out, flip_out, degree_out, x_out, y_out} = head_data;

endmodule

// File: tb/tb_cordic_input_stage.sv
module tb_cordic_input_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] degree_out, x_out, y_out;
  logic [0:0]  flip_out;
  logic        arctan_en_out, out_valid;
  logic        out_ready = 1'b1;
`ifdef CORDIC_IN_CLAMP_EN
  logic        range_err;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    int deg;
    int flip;
    int y;
    int arc;
    int steps;
  } exp_t;

  cordic_input_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_word      (in_word),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .degree_out   (degree_out),
    .x_out        (x_out),
    .y_out        (y_out),
    .flip_out     (flip_out),
    .arctan_en_out(arctan_en_out),
    .out_valid    (out_valid),
`ifdef CORDIC_IN_CLAMP_EN
    .range_err    (range_err),
`endif
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: wrap by whole turns into [-180,180], then fold by a half turn.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   a;
    e.steps = 0;
    e.arc   = int'(w[16]);
    if (w[16]) begin
      e.deg  = 0;
      e.flip = 0;
      e.y    = int'(w[15:0]);
      return e;
    end
    e.y = 0;
    a   = int'($signed(w[15:0]));
`ifdef CORDIC_IN_CLAMP_EN
    if (a > 180) a = 180;
    else if (a < -180) a = -180;
`else
    while (a > 180) begin a -= 360; e.steps++; end
    while (a < -180) begin a += 360; e.steps++; end
`endif
    if (a > 90) begin e.deg = a - 180; e.flip = 1; end
    else if (a < -90) begin e.deg = a + 180; e.flip = 1; end
    else begin e.deg = a; e.flip = 0; end
    return e;
  endfunction

  function automatic logic [31:0] rot(input int d);
    logic [15:0] t;
    t = d[15:0];
    return {16'h0000, t};
  endfunction

  task automatic check_head(input exp_t e);
    chk("degree", int'($signed(degree_out)), e.deg);
    chk("flip", int'(flip_out), e.flip);
    chk("x", int'(x_out), 256);
    chk("y", int'(y_out), e.y);
    chk("arctan", int'(arctan_en_out), e.arc);
  endtask

  task automatic send_only(input logic [31:0] w);
    int cyc;
    cyc = 0;
    in_word  = w;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!in_ready && cyc < 300);
    chk("accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_check(input logic [31:0] w);
    exp_t e;
    int   lat;
    int   rdy_low;
    e = model(w);
    send_only(w);
    lat = 1;
    rdy_low = 1;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 200) break;
      if (in_ready) rdy_low = 0;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, e.steps + 2);
    chk("ready_low_in_flight", rdy_low, 1);
    check_head(e);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t        q[$];
    logic [31:0] w;
    int          n, cyc, acc, quiet;

    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_degree", int'(degree_out), 0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;

    // Directed angles, boundaries, reductions and arctan mode.
    send_check(rot(45));
    send_check(rot(135));
    send_check(rot(-180));
    send_check(rot(180));
    send_check(rot(90));
    send_check(rot(-90));
    send_check(rot(-135));
    send_check(rot(400));
    send_check(rot(-32768));
    send_check(rot(32767));
    send_check(32'h0001_0180);
    send_check(32'hFFFE_002D);

    // Random commands, upper ignored bits included.
    for (int i = 0; i < 24; i++) begin
      w = $urandom;
      w[16] = ($urandom_range(0, 3) == 0);
      send_check(w);
    end

    // Fill the FIFO with the sink stalled, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = rot(int'($urandom_range(0, 720)) - 360);
      q.push_back(model(w));
      send_only(w);
    end
    repeat (3) @(posedge clk);
    #1;
    w = rot(77);
    q.push_back(model(w));
    in_word  = w;
    in_valid = 1'b1;
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) quiet = 0;
    end
    chk("full_blocks_ready", quiet, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 200) begin
      @(negedge clk);
      acc = int'(in_valid && in_ready);
      if (out_valid) begin
        check_head(q[n]);
        n++;
      end
      @(posedge clk); #1;
      if (acc != 0) in_valid = 1'b0;
      cyc++;
    end
    chk("drain_count", n, 5);
    chk("fifth_accepted", int'(in_valid), 0);

    // Reset while a long reduction is in flight with an entry queued.
    out_ready = 1'b0;
    send_only(rot(45));
    repeat (2) @(posedge clk);
    #1;
    send_only(rot(-32768));
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_degree", int'(degree_out), 0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    quiet = 1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (out_valid) quiet = 0;
    end
    chk("no_replay", quiet, 1);
    @(posedge clk); #1;
    send_check(rot(-100));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
